// File: rtl/mmd_dsm_ctrl.sv
// mmd_dsm_ctrl: fractional-N sequencer for the 6-stage multi-modulus divider.
// Produces one DIVNUM per divided-clock period. The value is the integer FCW
// plus a MASH 1-1-1 delta-sigma noise term, clamped to the divider's legal
// range. The block also owns the FCW capture handshake.
//
// Ports
//   ckvd       divided clock from the MMD (sole clock)
//   nrst       synchronous active-low reset
//   dsm_en     1 = delta-sigma modulation, 0 = integer-only division
//   dither_en  add LFSR LSB dither to the first accumulator input
//   fcw_vld    new FCW presented, held until fcw_ack is seen
//   fcw_i      integer part of the divide ratio
//   fcw_f      fractional part, unsigned, scaled by 2^-FRAC_W
//   fcw_ack    one-cycle pulse confirming FCW capture
//   divnum     registered modulus to the MMD
//   clamp      high in any cycle whose divnum was saturated
module mmd_dsm_ctrl #(
    parameter int unsigned FRAC_W  = 16,
    parameter int unsigned DIV_RST = 4,
    parameter int unsigned DIV_MIN = 4,
    parameter int unsigned DIV_MAX = 127
) (
    input  logic              ckvd,
    input  logic              nrst,
    input  logic              dsm_en,
    input  logic              dither_en,
    input  logic              fcw_vld,
    input  logic [6:0]        fcw_i,
    input  logic [FRAC_W-1:0] fcw_f,
    output logic              fcw_ack,
    output logic [6:0]        divnum,
    output logic              clamp
);

    localparam int unsigned NW    = 7;
    localparam int unsigned SW    = FRAC_W + 1;
    localparam int unsigned YW    = 4;
    localparam int unsigned TW    = 9;
    localparam int unsigned LW    = 15;

    // Clamp bounds as signed values so comparisons against t stay signed.
    localparam logic signed [TW-1:0] MIN_S = TW'(DIV_MIN);
    localparam logic signed [TW-1:0] MAX_S = TW'(DIV_MAX);

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    // Registered state
    state_t            state;
    logic [NW-1:0]     n_act;
    logic [FRAC_W-1:0] f_act;
    logic [FRAC_W-1:0] acc1;
    logic [FRAC_W-1:0] acc2;
    logic [FRAC_W-1:0] acc3;
    logic              c2_d1;
    logic              c3_d1;
    logic              c3_d2;
    logic [LW-1:0]     lfsr;

    // Next-state values
    state_t            state_nxt;
    logic [NW-1:0]     n_act_nxt;
    logic [FRAC_W-1:0] f_act_nxt;
    logic [FRAC_W-1:0] acc1_nxt;
    logic [FRAC_W-1:0] acc2_nxt;
    logic [FRAC_W-1:0] acc3_nxt;
    logic              c2_d1_nxt;
    logic              c3_d1_nxt;
    logic              c3_d2_nxt;
    logic [LW-1:0]     lfsr_nxt;
    logic              fcw_ack_nxt;
    logic [NW-1:0]     divnum_nxt;
    logic              clamp_nxt;

    // Datapath intermediates
    logic              dith;
    logic [SW-1:0]     s1;
    logic [SW-1:0]     s2;
    logic [SW-1:0]     s3;
    logic              c1;
    logic              c2;
    logic              c3;
    logic [YW-1:0]     y;
    logic signed [TW-1:0] t;

    // State register; every register is forced on reset.
    always_ff @(posedge ckvd) begin
        if (!nrst) begin
            state   <= ST_OFF;
            n_act   <= NW'(DIV_RST);
            f_act   <= '0;
            acc1    <= '0;
            acc2    <= '0;
            acc3    <= '0;
            c2_d1   <= 1'b0;
            c3_d1   <= 1'b0;
            c3_d2   <= 1'b0;
            lfsr    <= LW'(1);
            fcw_ack <= 1'b0;
            divnum  <= NW'(DIV_RST);
            clamp   <= 1'b0;
        end else begin
            state   <= state_nxt;
            n_act   <= n_act_nxt;
            f_act   <= f_act_nxt;
            acc1    <= acc1_nxt;
            acc2    <= acc2_nxt;
            acc3    <= acc3_nxt;
            c2_d1   <= c2_d1_nxt;
            c3_d1   <= c3_d1_nxt;
            c3_d2   <= c3_d2_nxt;
            lfsr    <= lfsr_nxt;
            fcw_ack <= fcw_ack_nxt;
            divnum  <= divnum_nxt;
            clamp   <= clamp_nxt;
        end
    end

    // Next-state, MASH datapath, clamp and handshake.
    always_comb begin
        state_nxt   = state;
        n_act_nxt   = n_act;
        f_act_nxt   = f_act;
        acc1_nxt    = acc1;
        acc2_nxt    = acc2;
        acc3_nxt    = acc3;
        c2_d1_nxt   = c2_d1;
        c3_d1_nxt   = c3_d1;
        c3_d2_nxt   = c3_d2;
        lfsr_nxt    = lfsr;
        fcw_ack_nxt = 1'b0;
        divnum_nxt  = divnum;
        clamp_nxt   = 1'b0;

        // MASH 1-1-1: each stage integrates the previous stage's residue.
        dith = dither_en & lfsr[0];
        s1   = SW'(acc1) + SW'(f_act) + SW'(dith);
        s2   = SW'(acc2) + SW'(s1[FRAC_W-1:0]);
        s3   = SW'(acc3) + SW'(s2[FRAC_W-1:0]);
        c1   = s1[FRAC_W];
        c2   = s2[FRAC_W];
        c3   = s3[FRAC_W];

        // Noise shaping y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3, modulo 16,
        // read back as signed; the true range -3..+4 fits without wrap.
        y = YW'(c1) + YW'(c2) - YW'(c2_d1)
          + YW'(c3) - YW'({c3_d1, 1'b0}) + YW'(c3_d2);

        // Mode transitions
        case (state)
            ST_OFF:  if (dsm_en)  state_nxt = ST_RUN;
            ST_RUN:  if (!dsm_en) state_nxt = ST_OFF;
            default: state_nxt = ST_OFF;
        endcase

        if (state == ST_RUN) begin
            acc1_nxt  = s1[FRAC_W-1:0];
            acc2_nxt  = s2[FRAC_W-1:0];
            acc3_nxt  = s3[FRAC_W-1:0];
            c2_d1_nxt = c2;
            c3_d1_nxt = c3;
            c3_d2_nxt = c3_d1;
            // x^15 + x^14 + 1 Fibonacci LFSR
            lfsr_nxt  = {lfsr[LW-2:0], lfsr[14] ^ lfsr[13]};
            t = $signed({2'b00, n_act}) + $signed({{(TW-YW){y[YW-1]}}, y});
        end else begin
            acc1_nxt  = '0;
            acc2_nxt  = '0;
            acc3_nxt  = '0;
            c2_d1_nxt = 1'b0;
            c3_d1_nxt = 1'b0;
            c3_d2_nxt = 1'b0;
            t = $signed({2'b00, n_act});
        end

        // Saturate to the divider's legal modulus range.
        if (t < MIN_S) begin
            divnum_nxt = NW'(DIV_MIN);
            clamp_nxt  = 1'b1;
        end else if (t > MAX_S) begin
            divnum_nxt = NW'(DIV_MAX);
            clamp_nxt  = 1'b1;
        end else begin
            divnum_nxt = t[NW-1:0];
        end

        // Capture only when the previous ack has retired: a held fcw_vld
        // is therefore accepted at most every second cycle.
        if (fcw_vld && !fcw_ack) begin
            n_act_nxt   = fcw_i;
            f_act_nxt   = fcw_f;
            fcw_ack_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_mmd_dsm_ctrl.sv
// Testbench for mmd_dsm_ctrl: directed phases plus randomized traffic,
// every cycle compared against an arithmetic reference model.
module tb_mmd_dsm_ctrl;

    logic        ckvd = 1'b0;
    logic        nrst;
    logic        dsm_en;
    logic        dither_en;
    logic        fcw_vld;
    logic [6:0]  fcw_i;
    logic [15:0] fcw_f;
    logic        fcw_ack;
    logic [6:0]  divnum;
    logic        clamp;

    always #5 ckvd = ~ckvd;

    mmd_dsm_ctrl #(
        .FRAC_W (16),
        .DIV_RST(4),
        .DIV_MIN(4),
        .DIV_MAX(127)
    ) dut (
        .ckvd     (ckvd),
        .nrst     (nrst),
        .dsm_en   (dsm_en),
        .dither_en(dither_en),
        .fcw_vld  (fcw_vld),
        .fcw_i    (fcw_i),
        .fcw_f    (fcw_f),
        .fcw_ack  (fcw_ack),
        .divnum   (divnum),
        .clamp    (clamp)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers)
    int m_n, m_f, m_a1, m_a2, m_a3, m_c2d, m_c3d1, m_c3d2, m_lfsr;
    int m_div;
    bit m_run, m_ack, m_clamp, m_run_edge;

    // Observation trackers
    longint sum;
    int     run_cnt;
    bit     sum_en;
    int     obs_min, obs_max;
    bit     clamp_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One CKVD edge of the reference behaviour, from the inputs at that edge.
    task automatic model_edge();
        int s1, s2, s3, c1, c2, c3, y, t, d;
        m_run_edge = 1'b0;
        if (!nrst) begin
            m_run = 0; m_n = 4; m_f = 0; m_div = 4; m_clamp = 0; m_ack = 0;
            m_a1 = 0; m_a2 = 0; m_a3 = 0; m_c2d = 0; m_c3d1 = 0; m_c3d2 = 0;
            m_lfsr = 1;
        end else begin
            if (m_run) begin
                m_run_edge = 1'b1;
                d  = dither_en ? (m_lfsr & 1) : 0;
                s1 = m_a1 + m_f + d;  c1 = s1 / 65536; m_a1 = s1 % 65536;
                s2 = m_a2 + m_a1;     c2 = s2 / 65536; m_a2 = s2 % 65536;
                s3 = m_a3 + m_a2;     c3 = s3 / 65536; m_a3 = s3 % 65536;
                y  = c1 + (c2 - m_c2d) + (c3 - 2 * m_c3d1 + m_c3d2);
                m_c3d2 = m_c3d1; m_c3d1 = c3; m_c2d = c2;
                m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7fff;
                t = m_n + y;
            end else begin
                m_a1 = 0; m_a2 = 0; m_a3 = 0; m_c2d = 0; m_c3d1 = 0; m_c3d2 = 0;
                t = m_n;
            end
            if (t < 4)        begin m_div = 4;   m_clamp = 1; end
            else if (t > 127) begin m_div = 127; m_clamp = 1; end
            else              begin m_div = t;   m_clamp = 0; end
            m_run = dsm_en;
            if (fcw_vld && !m_ack) begin
                m_n = fcw_i; m_f = fcw_f; m_ack = 1;
            end else begin
                m_ack = 0;
            end
        end
    endtask

    // Advance one cycle, then compare all outputs 1 time unit after the edge.
    task automatic cyc();
        @(posedge ckvd);
        model_edge();
        #1;
        check("divnum", 32'(divnum), 32'(m_div));
        check("clamp", 32'(clamp), 32'(m_clamp));
        check("fcw_ack", 32'(fcw_ack), 32'(m_ack));
        if (sum_en && m_run_edge && run_cnt < 65536) begin
            sum += longint'(divnum);
            run_cnt++;
        end
        if (int'(divnum) < obs_min) obs_min = int'(divnum);
        if (int'(divnum) > obs_max) obs_max = int'(divnum);
        if (clamp) clamp_seen = 1'b1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic track_reset();
        obs_min = 1000; obs_max = -1; clamp_seen = 1'b0;
    endtask

    // Present one FCW for a single edge, then release fcw_vld.
    task automatic handshake(input logic [6:0] ni, input logic [15:0] nf);
        fcw_vld = 1'b1; fcw_i = ni; fcw_f = nf;
        cyc();
        fcw_vld = 1'b0;
    endtask

    logic [5:0] pat;

    initial begin
        nrst = 1'b0; dsm_en = 1'b0; dither_en = 1'b0; fcw_vld = 1'b0;
        fcw_i = '0; fcw_f = '0;
        sum = 0; run_cnt = 0; sum_en = 1'b0;
        track_reset();

        // Reset and idle: divnum parked at 4
        cycles(3);
        nrst = 1'b1;
        cycles(100);
        check("idle_divnum_exact", 32'(divnum), 32'd4);

        // Integer-only ratio
        handshake(7'd10, 16'h1234);
        cycles(20);
        check("int_divnum_exact", 32'(divnum), 32'd10);

        // Fractional 20.5, no dither, first 65536 RUN outputs
        handshake(7'd20, 16'h8000);
        dsm_en = 1'b1;
        sum_en = 1'b1; sum = 0; run_cnt = 0;
        track_reset();
        cyc();
        cycles(65537);
        sum_en = 1'b0;
        check("frac_run_count", 32'(run_cnt), 32'd65536);
        check("frac_sum_in_band",
              32'((sum >= 20 * 65536 + 32768 - 4) && (sum <= 20 * 65536 + 32768 + 4)), 32'd1);
        check("frac_min_ge17", 32'(obs_min >= 17), 32'd1);
        check("frac_max_le24", 32'(obs_max <= 24), 32'd1);

        // Mid-RUN FCW update without phase reset
        handshake(7'd33, 16'h1357);
        cycles(50);

        // Low-side clamp
        handshake(7'd4, 16'h4000);
        track_reset();
        cycles(64);
        check("clamp_low_seen", 32'(clamp_seen), 32'd1);
        check("clamp_low_min", 32'(obs_min >= 4), 32'd1);

        // High-side clamp
        handshake(7'd125, 16'hc000);
        track_reset();
        cycles(200);
        check("clamp_high_seen", 32'(clamp_seen), 32'd1);
        check("clamp_high_max", 32'(obs_max), 32'd127);

        // Held fcw_vld: captures every second cycle
        dsm_en = 1'b0;
        cycles(4);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            fcw_vld = 1'b1; fcw_i = 7'(30 + i); fcw_f = 16'h0;
            cyc();
            pat = {pat[4:0], fcw_ack};
        end
        fcw_vld = 1'b0;
        check("ack_pattern", 32'(pat), 32'b101010);
        cycles(3);
        check("held_vld_last_capture", 32'(divnum), 32'd34);

        // Reset mid-RUN with a pending capture that must be dropped
        handshake(7'd50, 16'h2468);
        dsm_en = 1'b1; dither_en = 1'b1;
        cycles(40);
        nrst = 1'b0; fcw_vld = 1'b1; fcw_i = 7'd90; fcw_f = 16'h7777;
        cyc();
        check("rst_midrun_divnum", 32'(divnum), 32'd4);
        nrst = 1'b1; fcw_vld = 1'b0; dsm_en = 1'b0; dither_en = 1'b0;
        cycles(10);
        check("rst_idle_divnum", 32'(divnum), 32'd4);
        dsm_en = 1'b1;
        cycles(10);
        check("rst_no_handshake_divnum", 32'(divnum), 32'd4);
        handshake(7'd60, 16'h3000);
        cycles(30);

        // Randomized traffic: mode toggles, dither, FCW updates, rare resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(49, 0) == 0) dsm_en = ~dsm_en;
            if ($urandom_range(99, 0) == 0) dither_en = ~dither_en;
            fcw_vld = ($urandom_range(19, 0) == 0);
            fcw_i   = ($urandom_range(3, 0) == 0) ? 7'($urandom_range(127, 0))
                                                  : 7'($urandom_range(123, 7));
            fcw_f   = 16'($urandom);
            nrst    = ($urandom_range(499, 0) != 0);
            cyc();
        end
        nrst = 1'b1; fcw_vld = 1'b0;
        cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmd_dsm_ctrl.md
# mmd_dsm_ctrl

Fractional-N sequencer for the 6-stage multi-modulus divider. It runs on the divided clock CKVD and computes a new DIVNUM every output period. The integer part of the frequency control word (FCW) is added to a third-order MASH 1-1-1 delta-sigma sequence driven by the fractional part. The result is clamped to the divider's legal range of 4..127. It also owns the FCW update handshake toward the frequency-planning logic.

## Interface
- FRAC_W, 16: fractional FCW width; accumulator width.
- DIV_RST, 4: DIVNUM value and active integer word after reset.
- DIV_MIN, 4: lower clamp bound for DIVNUM.
- DIV_MAX, 127: upper clamp bound for DIVNUM.
- CKVD  in  1  divided clock from the MMD; sole clock of the block.
- NRST  in  1  reset; synchronous, active-low.
- DSM_EN  in  1  1 = delta-sigma modulation active; 0 = integer-only division.
- DITHER_EN  in  1  adds LFSR LSB dither to the first accumulator input.
- FCW_VLD  in  1  new FCW presented; held until FCW_ACK is seen.
- FCW_I  in  7  integer part of the requested divide ratio.
- FCW_F  in  FRAC_W  fractional part (unsigned, scaled by 2^-FRAC_W).
- FCW_ACK  out  1  one-cycle pulse confirming FCW capture.
- DIVNUM  out  7  registered modulus to the MMD DIVNUM port.
- CLAMP  out  1  high in any cycle whose DIVNUM was saturated.

## Operation
- Active registers n_act[6:0] and f_act[FRAC_W-1:0] are loaded only through the handshake.
- Handshake:
  - At an edge with FCW_VLD=1 and FCW_ACK=0: n_act<=FCW_I, f_act<=FCW_F, FCW_ACK<=1.
  - At an edge with FCW_ACK=1: FCW_ACK<=0 and no capture.
  - A continuously high FCW_VLD is therefore accepted at most every second cycle.
- FSM, two states:
  - OFF (reset state).
  - OFF→RUN when DSM_EN=1 is sampled.
  - RUN→OFF when DSM_EN=0 is sampled.
  - In OFF: accumulators acc1..acc3, carry delays c2_d1, c3_d1, c3_d2 are held at 0.
- RUN, every edge, with s1/s2/s3 the (FRAC_W+1)-bit sums:
  - s1 = acc1 + f_act + d, where d = LFSR[0] if DITHER_EN else 0.
  - s2 = acc2 + s1[FRAC_W-1:0].
  - s3 = acc3 + s2[FRAC_W-1:0].
  - Carries: c1 = s1[FRAC_W], c2 = s2[FRAC_W], c3 = s3[FRAC_W].
  - Accumulators take the low FRAC_W bits; wrap modulo 2^FRAC_W.
  - Noise term y = c1 + (c2 − c2_d1) + (c3 − 2·c3_d1 + c3_d2), signed, range −3..+4.
  - Compute y in at least 4-bit signed arithmetic.
  - Delays update: c2_d1<=c2, c3_d1<=c3, c3_d2<=c3_d1.
- Sum t = n_act + y:
  - Signed 9-bit in RUN; t = n_act in OFF.
  - DIVNUM <= min(max(t, DIV_MIN), DIV_MAX).
  - CLAMP <= 1 iff saturation occurred that edge.
  - n_act in 7..123 never clamps.
- LFSR:
  - 15-bit, x^15+x^14+1, seed 15'h0001 at reset.
  - Advances every cycle in RUN regardless of DITHER_EN.
- FCW update during RUN:
  - Accumulator and delay state is not cleared.
  - The new f_act takes effect from the next edge, with no phase reset.
- Reset (NRST=0 sampled), including mid-RUN; every register is forced:
  - State OFF.
  - DIVNUM=DIV_RST, n_act=DIV_RST, f_act=0.
  - Accumulators and delays 0, LFSR=1.
  - FCW_ACK=0, CLAMP=0.
  - A capture pending in the same cycle is discarded.

## Timing
- All outputs registered on posedge CKVD.
- Capture-to-output latency:
  - FCW captured at edge k; FCW_ACK high in cycle k..k+1.
  - DIVNUM reflects the new n_act and the first new-f_act carry at edge k+1.
- DSM_EN sampled 1 at edge k: first modulated DIVNUM at edge k+1.
- DSM_EN sampled 0 at edge k: DIVNUM = clamp(n_act) from edge k+1.
- The MMD retimes DIVNUM through two posedge CKVD stages. End-to-end, a value issued at edge k governs the divide ratio from CKVD edge k+2.
- Simultaneous FCW capture and DSM_EN change at one edge: both take effect. The next computation uses the new FCW in the new mode.

## Test plan
- Reset, then FCW_VLD never asserted, DSM_EN=0 → DIVNUM=4, CLAMP=0, FCW_ACK=0 for 100 cycles.
- Integer-only: handshake FCW_I=10, FCW_F=0x1234, DSM_EN=0 → FCW_ACK single pulse; DIVNUM=10 constant from the next edge.
- Fractional, DITHER_EN=0:
  - Stimulus: FCW_I=20, FCW_F=0x8000, DSM_EN=1.
  - DIVNUM stays within 17..24.
  - Sum over the first 65536 RUN cycles equals 20·65536+32768 ±4.
  - Output matches a bit-exact MASH 1-1-1 reference model.
- Clamp: FCW_I=4, FCW_F=0x4000, DSM_EN=1 → DIVNUM≥4 at all times; CLAMP asserted at least once within 64 cycles; FCW_I=125 case → DIVNUM≤127.
- Handshake: FCW_VLD held high for 6 cycles with changing FCW_I → captures at cycles 0, 2, 4 only; FCW_ACK pattern 1,0,1,0,1,0.
- Reset mid-RUN: NRST low for one cycle during modulation → next edge DIVNUM=4, state OFF, accumulators 0; after release, resumes only after a new handshake plus DSM_EN.
